// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//   Command arbiter between the init, auto-refresh, write and read
//   sub-controllers and the SDRAM pins. After initialization completes it
//   grants one requester at a time with fixed priority
//   refresh > write > read. The granted requester owns the command, bank and
//   address pins until it signals *_end. Every grant is followed by at least
//   one ARBIT (NOP) cycle.
//
// Ports
//   ar_clk, ar_rst_n          clock, asynchronous active-low reset
//   init_end/cmd/bank/addr    init sequencer status and command
//   ar_req/end/cmd/bank/addr  refresher request, done pulse and command; ar_en grant
//   wr_req/end/cmd/bank/addr  writer request, done pulse and command; wr_en grant
//   wr_dq_oe, wr_dq           writer DQ enable and data
//   rd_req/end/cmd/bank/addr  reader request, done pulse and command; rd_en grant
//   sdram_*                   SDRAM pins (cke, command, bank, address, DQ out)
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter int DATA_W = 16
) (
  input  logic              ar_clk,
  input  logic              ar_rst_n,

  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [12:0]       init_addr,

  input  logic              ar_req,
  input  logic              ar_end,
  input  logic [3:0]        ar_cmd,
  input  logic [1:0]        ar_bank,
  input  logic [12:0]       ar_addr,
  output logic              ar_en,

  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [12:0]       wr_addr,
  input  logic              wr_dq_oe,
  input  logic [DATA_W-1:0] wr_dq,
  output logic              wr_en,

  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [12:0]       rd_addr,
  output logic              rd_en,

  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [12:0]       sdram_addr,
  output logic              sdram_dq_oe,
  output logic [DATA_W-1:0] sdram_dq_out
);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [1:0]  BANK_IDL = 2'b11;
  localparam logic [12:0] ADDR_IDL = 13'h1fff;

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t state_q, state_d;
  logic   ar_en_q, ar_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;
  logic   cke_q,   cke_d;

  logic [3:0]  cmd_sel;
  logic [1:0]  bank_sel;
  logic [12:0] addr_sel;

  // State, grant and clock-enable registers
  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      state_q <= S_INIT;
      ar_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_en_q <= ar_en_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      cke_q   <= cke_d;
    end
  end

  // Next state. Operations are never preempted; only the owner's *_end
  // releases the bus, and the release always passes through ARBIT so a new
  // grant is at least one NOP cycle away.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ar_req)      state_d = S_AREF;
        else if (wr_req) state_d = S_WRITE;
        else if (rd_req) state_d = S_READ;
      end
      S_AREF:  if (ar_end) state_d = S_ARBIT;
      S_WRITE: if (wr_end) state_d = S_ARBIT;
      S_READ:  if (rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  // Grants are decoded from the next state so they rise with the state and
  // drop on the same edge the state returns to ARBIT; the sub-controller
  // therefore never sees its grant in the cycle after its own *_end.
  always_comb begin
    ar_en_d = (state_d == S_AREF);
    wr_en_d = (state_d == S_WRITE);
    rd_en_d = (state_d == S_READ);
    cke_d   = 1'b1;
  end

  // Pin mux from the registered state
  always_comb begin
    cmd_sel  = CMD_NOP;
    bank_sel = BANK_IDL;
    addr_sel = ADDR_IDL;
    unique case (state_q)
      S_INIT: begin
        cmd_sel  = init_cmd;
        bank_sel = init_bank;
        addr_sel = init_addr;
      end
      S_AREF: begin
        cmd_sel  = ar_cmd;
        bank_sel = ar_bank;
        addr_sel = ar_addr;
      end
      S_WRITE: begin
        cmd_sel  = wr_cmd;
        bank_sel = wr_bank;
        addr_sel = wr_addr;
      end
      S_READ: begin
        cmd_sel  = rd_cmd;
        bank_sel = rd_bank;
        addr_sel = rd_addr;
      end
      default: begin
        cmd_sel  = CMD_NOP;
        bank_sel = BANK_IDL;
        addr_sel = ADDR_IDL;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_ba     = bank_sel;
  assign sdram_addr   = addr_sel;
  // The writer only owns DQ while it holds the bus
  assign sdram_dq_oe  = (state_q == S_WRITE) ? wr_dq_oe : 1'b0;
  assign sdram_dq_out = (state_q == S_WRITE) ? wr_dq : '0;

  assign ar_en     = ar_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
//   Directed bench for sdram_arbit. A bus-ownership model (who owns the pins,
//   whether init has completed) predicts every output and is compared on each
//   falling edge; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int DATA_W = 16;

  logic              ar_clk = 1'b0;
  logic              ar_rst_n;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [12:0]       init_addr;
  logic              ar_req, ar_end;
  logic [3:0]        ar_cmd;
  logic [1:0]        ar_bank;
  logic [12:0]       ar_addr;
  logic              ar_en;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [12:0]       wr_addr;
  logic              wr_dq_oe;
  logic [DATA_W-1:0] wr_dq;
  logic              wr_en;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [12:0]       rd_addr;
  logic              rd_en;
  logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [12:0]       sdram_addr;
  logic              sdram_dq_oe;
  logic [DATA_W-1:0] sdram_dq_out;

  int checks = 0;
  int errors = 0;

  always #5 ar_clk = ~ar_clk;

  sdram_arbit #(.DATA_W(DATA_W)) dut (
    .ar_clk(ar_clk), .ar_rst_n(ar_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
    .ar_en(ar_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_dq_oe(wr_dq_oe), .wr_dq(wr_dq), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: owner 0 = nobody (idle/NOP), 1 = refresh, 2 = write, 3 = read
  int owner;
  bit inited;
  bit cke_m;

  always @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      owner  = 0;
      inited = 0;
      cke_m  = 0;
    end else begin
      cke_m = 1;
      if (!inited) begin
        if (init_end) inited = 1;
      end else if (owner == 0) begin
        if (ar_req)      owner = 1;
        else if (wr_req) owner = 2;
        else if (rd_req) owner = 3;
      end else if ((owner == 1 && ar_end) || (owner == 2 && wr_end) ||
                   (owner == 3 && rd_end)) begin
        owner = 0;
      end
    end
  end

  function automatic logic [18:0] exp_pins();
    if (!inited)     return {init_cmd, init_bank, init_addr};
    case (owner)
      1:       return {ar_cmd, ar_bank, ar_addr};
      2:       return {wr_cmd, wr_bank, wr_addr};
      3:       return {rd_cmd, rd_bank, rd_addr};
      default: return {4'b0111, 2'b11, 13'h1fff};
    endcase
  endfunction

  always @(negedge ar_clk) begin
    check("grants", {29'd0, ar_en, wr_en, rd_en},
          {29'd0, inited && owner == 1, inited && owner == 2, inited && owner == 3});
    check("pins", {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {13'd0, exp_pins()});
    check("cke", {31'd0, sdram_cke}, {31'd0, cke_m});
    check("dq", {15'd0, sdram_dq_oe, sdram_dq_out},
          (owner == 2) ? {15'd0, wr_dq_oe, wr_dq} : 32'd0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ar_clk);
    #1;
  endtask

  function automatic logic [3:0] pin_cmd();
    return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  endfunction

  initial begin
    ar_rst_n = 1'b0;
    init_end = 0; init_cmd = 4'b0111; init_bank = 2'b11; init_addr = 13'h1fff;
    ar_req = 0; ar_end = 0; ar_cmd = 4'b0001; ar_bank = 2'b00; ar_addr = 13'h0123;
    wr_req = 0; wr_end = 0; wr_cmd = 4'b0100; wr_bank = 2'b10; wr_addr = 13'h0aaa;
    wr_dq_oe = 0; wr_dq = '0;
    rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_bank = 2'b01; rd_addr = 13'h0555;

    // Reset state
    tick(3);
    check("rst_cke", {31'd0, sdram_cke}, 32'd0);
    check("rst_grants", {29'd0, ar_en, wr_en, rd_en}, 32'd0);
    check("rst_cmd", {28'd0, pin_cmd()}, 32'h7);
    check("rst_ba_addr", {17'd0, sdram_ba, sdram_addr}, {17'd0, 2'b11, 13'h1fff});

    // Init phase: requests are not granted while init is running
    ar_rst_n = 1'b1;
    init_cmd = 4'b0010; init_bank = 2'b01; init_addr = 13'h0400;
    ar_req = 1;
    tick(50);
    check("init_ar_en", {31'd0, ar_en}, 32'd0);
    check("init_cmd", {28'd0, pin_cmd()}, 32'h2);
    check("init_cke", {31'd0, sdram_cke}, 32'd1);

    // Init done: one ARBIT cycle, then refresh wins over write and read
    init_end = 1;
    wr_req = 1; rd_req = 1;
    tick();
    check("arbit_nop", {28'd0, pin_cmd()}, 32'h7);
    check("arbit_ar_en", {31'd0, ar_en}, 32'd0);
    tick();
    check("aref_grants", {29'd0, ar_en, wr_en, rd_en}, 32'b100);
    check("aref_cmd", {28'd0, pin_cmd()}, 32'h1);
    init_end = 0;  // ignored from now on
    tick(3);
    ar_end = 1; ar_req = 0;
    tick();
    ar_end = 0;
    check("aref_done_en", {31'd0, ar_en}, 32'd0);
    check("gap_addr", {19'd0, sdram_addr}, 32'h1fff);
    tick();
    check("write_grant", {29'd0, ar_en, wr_en, rd_en}, 32'b010);

    // Write: DQ driven; refresh request and a stray rd_end arrive mid-write
    wr_dq_oe = 1; wr_dq = 16'hA5A5;
    #1;
    check("wr_cmd", {28'd0, pin_cmd()}, 32'h4);
    check("wr_dq_oe", {31'd0, sdram_dq_oe}, 32'd1);
    check("wr_dq", {16'd0, sdram_dq_out}, 32'h0000A5A5);
    tick();
    ar_req = 1; rd_end = 1;
    tick();
    rd_end = 0;
    tick(2);
    check("wr_hold", {29'd0, ar_en, wr_en, rd_en}, 32'b010);
    wr_end = 1; wr_req = 0;
    tick();
    wr_end = 0;
    check("wr_release", {30'd0, wr_en, sdram_dq_oe}, 32'd0);
    tick();
    check("ar_over_rd", {29'd0, ar_en, wr_en, rd_en}, 32'b100);

    // Refresh end coincides with read still requesting
    tick(2);
    ar_end = 1; ar_req = 0;
    tick();
    ar_end = 0;
    tick();
    check("read_grant", {29'd0, ar_en, wr_en, rd_en}, 32'b001);
    check("rd_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    check("rd_cmd", {28'd0, pin_cmd()}, 32'h5);
    tick(2);

    // Asynchronous reset mid-read
    ar_rst_n = 1'b0;
    #1;
    check("arst_rd_en", {31'd0, rd_en}, 32'd0);
    check("arst_cke", {31'd0, sdram_cke}, 32'd0);
    check("arst_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    init_end = 0;
    tick(2);
    ar_rst_n = 1'b1;
    tick();
    check("post_rst_cke", {31'd0, sdram_cke}, 32'd1);
    check("post_rst_init", {28'd0, pin_cmd()}, 32'h2);
    check("post_rst_rd_en", {31'd0, rd_en}, 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
